// File: rtl/fp_align_pkg.sv
// Shared types and constants for the FP adder alignment sequencer.
package fp_align_pkg;

    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int EXT_W     = 26;
    localparam int MAX_SHIFT = 26;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SPC_NORMAL = 2'b00,
        SPC_ZERO   = 2'b01,
        SPC_INFNAN = 2'b10
    } special_e;

    // Anything past the full extended width shifts out entirely, so clamp there.
    function automatic logic [4:0] clampShift(input logic [EXP_W-1:0] diff);
        return (diff > EXP_W'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : 5'(diff);
    endfunction

endpackage

// File: rtl/fp_operand_classify.sv
// Splits one single-precision operand into class, exponent and extended mantissa,
// flushing denormals to zero.
module fp_operand_classify
    import fp_align_pkg::*;
(
    input  logic [31:0]      op_i,
    output logic [1:0]       class_o,
    output logic [EXP_W-1:0] exp_o,
    output logic [EXT_W-1:0] ext_o
);

    logic [FRAC_W-1:0] frac;
    logic              unusedSign;

    assign exp_o      = op_i[30:23];
    assign frac       = op_i[22:0];
    assign unusedSign = op_i[31];

    // Inf/NaN keeps its fraction with no hidden bit; exp==0 is treated as a true zero.
    always_comb begin
        class_o = SPC_NORMAL;
        ext_o   = {1'b1, frac, 2'b00};
        if (exp_o == EXP_SPECIAL) begin
            class_o = SPC_INFNAN;
            ext_o   = {1'b0, frac, 2'b00};
        end else if (exp_o == '0) begin
            class_o = SPC_ZERO;
            ext_o   = '0;
        end
    end

endmodule

// File: rtl/fp_align_seq.sv
// Multi-cycle exponent alignment for the FP adder: shifts the smaller operand right
// a bounded number of bits per cycle while collecting guard/round/sticky.
module fp_align_seq
    import fp_align_pkg::*;
#(
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] aligned_a,
    output logic [23:0] aligned_b,
    output logic [7:0]  exp_out,
    output logic        guard,
    output logic        round,
    output logic        sticky,
    output logic [1:0]  special
);

    localparam logic [4:0] STEP_MAX = 5'(SHIFT_PER_CYCLE);

    state_e           state_q, state_d;
    logic [EXT_W-1:0] extA_q, extA_d, extB_q, extB_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [4:0]       remaining_q, remaining_d;
    logic             shiftB_q, shiftB_d;
    logic             sticky_q, sticky_d;
    logic [1:0]       special_q, special_d;

    logic [1:0]       classA, classB;
    logic [EXP_W-1:0] expA, expB;
    logic [EXT_W-1:0] extA, extB;

    logic             fire;
    logic             aGeB;
    logic [EXP_W-1:0] diff;
    logic [4:0]       step;
    logic [EXT_W-1:0] shiftee, shifted, lostMask;
    logic             lostAny;

    fp_operand_classify u_classA (
        .op_i    (a),
        .class_o (classA),
        .exp_o   (expA),
        .ext_o   (extA)
    );

    fp_operand_classify u_classB (
        .op_i    (b),
        .class_o (classB),
        .exp_o   (expB),
        .ext_o   (extB)
    );

    assign in_ready = (state_q == IDLE) && !reset;
    assign fire     = in_valid && in_ready;
    assign aGeB     = expA >= expB;
    assign diff     = aGeB ? (expA - expB) : (expB - expA);

    assign step     = (remaining_q < STEP_MAX) ? remaining_q : STEP_MAX;
    assign shiftee  = shiftB_q ? extB_q : extA_q;
    assign shifted  = shiftee >> step;
    assign lostMask = (EXT_W'(1) << step) - EXT_W'(1);
    assign lostAny  = |(shiftee & lostMask);

    // Capture and classify on fire, then peel off up to STEP_MAX bits per SHIFT cycle.
    always_comb begin
        state_d     = state_q;
        extA_d      = extA_q;
        extB_d      = extB_q;
        exp_d       = exp_q;
        remaining_d = remaining_q;
        shiftB_d    = shiftB_q;
        sticky_d    = sticky_q;
        special_d   = special_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    extA_d      = extA;
                    extB_d      = extB;
                    sticky_d    = 1'b0;
                    shiftB_d    = aGeB;
                    remaining_d = '0;
                    if (classA == SPC_INFNAN || classB == SPC_INFNAN) begin
                        exp_d     = EXP_SPECIAL;
                        special_d = SPC_INFNAN;
                    end else if (classA == SPC_ZERO || classB == SPC_ZERO) begin
                        exp_d     = (classA == SPC_ZERO) ? expB : expA;
                        special_d = SPC_ZERO;
                    end else begin
                        exp_d       = aGeB ? expA : expB;
                        special_d   = SPC_NORMAL;
                        remaining_d = clampShift(diff);
                    end
                    state_d = (remaining_d == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (shiftB_q) begin
                    extB_d = shifted;
                end else begin
                    extA_d = shifted;
                end
                sticky_d    = sticky_q | lostAny;
                remaining_d = remaining_q - step;
                if (remaining_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            extA_q      <= '0;
            extB_q      <= '0;
            exp_q       <= '0;
            remaining_q <= '0;
            shiftB_q    <= 1'b0;
            sticky_q    <= 1'b0;
            special_q   <= SPC_NORMAL;
        end else begin
            state_q     <= state_d;
            extA_q      <= extA_d;
            extB_q      <= extB_d;
            exp_q       <= exp_d;
            remaining_q <= remaining_d;
            shiftB_q    <= shiftB_d;
            sticky_q    <= sticky_d;
            special_q   <= special_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign aligned_a = extA_q[EXT_W-1:2];
    assign aligned_b = extB_q[EXT_W-1:2];
    assign exp_out   = exp_q;
    assign guard     = shiftB_q ? extB_q[1] : extA_q[1];
    assign round     = shiftB_q ? extB_q[0] : extA_q[0];
    assign sticky    = sticky_q;
    assign special   = special_q;

endmodule

// File: tb/tb_fp_align_seq.sv
// Scoreboard bench for fp_align_seq: one instance at SHIFT_PER_CYCLE=1 and one at 8
// share the same stimulus; a negedge monitor checks every DONE cycle of each.
module tb_fp_align_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        outReady;
    logic [31:0] a, b;

    logic        inReady  [2];
    logic        outValid [2];
    logic [23:0] alignedA [2];
    logic [23:0] alignedB [2];
    logic [7:0]  expOut   [2];
    logic        guardO   [2];
    logic        roundO   [2];
    logic        stickyO  [2];
    logic [1:0]  specialO [2];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  e;
        logic [23:0] aa;
        logic [23:0] ab;
        logic        g;
        logic        r;
        logic        s;
        logic [1:0]  spc;
        int          lat1;
        int          lat8;
    } vec_t;

    typedef struct {
        vec_t v;
        int   fireCyc;
    } exp_t;

    vec_t vecTab[$];
    exp_t expQ[$];
    exp_t cur[2];
    bit   inDone[2] = '{1'b0, 1'b0};
    int   rdIdx[2]  = '{0, 0};
    int   cyc = 0;
    int   nCompared = 0;
    int   nMismatched = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fp_align_seq #(.SHIFT_PER_CYCLE(g == 0 ? 1 : 8)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (inValid),
            .in_ready  (inReady[g]),
            .a         (a),
            .b         (b),
            .out_valid (outValid[g]),
            .out_ready (outReady),
            .aligned_a (alignedA[g]),
            .aligned_b (alignedB[g]),
            .exp_out   (expOut[g]),
            .guard     (guardO[g]),
            .round     (roundO[g]),
            .sticky    (stickyO[g]),
            .special   (specialO[g])
        );
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        nCompared++;
        if (act !== expv) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic addVec(input logic [31:0] va, input logic [31:0] vb, input logic [7:0] ve,
                          input logic [23:0] vaa, input logic [23:0] vab,
                          input logic vg, input logic vr, input logic vs,
                          input logic [1:0] vspc, input int l1, input int l8);
        vec_t v;
        v.a = va; v.b = vb; v.e = ve; v.aa = vaa; v.ab = vab;
        v.g = vg; v.r = vr; v.s = vs; v.spc = vspc; v.lat1 = l1; v.lat8 = l8;
        vecTab.push_back(v);
    endtask

    task automatic waitIdle();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(inReady[0] && inReady[1]) && n < 400);
        checkOutput("wait_idle", 32'(inReady[0] && inReady[1]), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        waitIdle();
        a = v.a;
        b = v.b;
        inValid = 1'b1;
        e.v = v;
        e.fireCyc = cyc;
        expQ.push_back(e);
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    // Pops one expectation per result and re-checks it on every cycle the result is held.
    always @(negedge clk) begin
        if (!reset) begin
            for (int g = 0; g < 2; g++) begin
                if (outValid[g]) begin
                    if (!inDone[g]) begin
                        if (rdIdx[g] < expQ.size()) begin
                            cur[g] = expQ[rdIdx[g]];
                            inDone[g] = 1'b1;
                            checkOutput($sformatf("dut%0d_latency", g), 32'(cyc - cur[g].fireCyc),
                                        32'((g == 0) ? cur[g].v.lat1 : cur[g].v.lat8));
                        end else begin
                            checkOutput($sformatf("dut%0d_unexpected_out", g), 32'(outValid[g]), 32'd0);
                        end
                    end
                    if (inDone[g]) begin
                        checkOutput($sformatf("dut%0d_exp_out", g), 32'(expOut[g]), 32'(cur[g].v.e));
                        checkOutput($sformatf("dut%0d_aligned_a", g), 32'(alignedA[g]), 32'(cur[g].v.aa));
                        checkOutput($sformatf("dut%0d_aligned_b", g), 32'(alignedB[g]), 32'(cur[g].v.ab));
                        checkOutput($sformatf("dut%0d_grs", g), 32'({guardO[g], roundO[g], stickyO[g]}),
                                    32'({cur[g].v.g, cur[g].v.r, cur[g].v.s}));
                        checkOutput($sformatf("dut%0d_special", g), 32'(specialO[g]), 32'(cur[g].v.spc));
                        checkOutput($sformatf("dut%0d_in_ready_done", g), 32'(inReady[g]), 32'd0);
                        if (outReady) begin
                            inDone[g] = 1'b0;
                            rdIdx[g]++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        reset    = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b1;
        a        = '0;
        b        = '0;

        //     a             b             exp    aligned_a  aligned_b  g     r     s     spc    l1  l8
        addVec(32'h3F800000, 32'h3F800000, 8'h7F, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0, 2'b00, 1, 1);
        addVec(32'h40000000, 32'h3F800001, 8'h80, 24'h800000, 24'h400000, 1'b1, 1'b0, 1'b0, 2'b00, 2, 2);
        addVec(32'h4B800000, 32'h3F800001, 8'h97, 24'h800000, 24'h000000, 1'b1, 1'b0, 1'b1, 2'b00, 25, 4);
        addVec(32'h53800000, 32'h3F800000, 8'hA7, 24'h800000, 24'h000000, 1'b0, 1'b0, 1'b1, 2'b00, 27, 5);
        addVec(32'h7F800000, 32'h3F800000, 8'hFF, 24'h000000, 24'h800000, 1'b0, 1'b0, 1'b0, 2'b10, 1, 1);
        addVec(32'h00000000, 32'h40400000, 8'h80, 24'h000000, 24'hC00000, 1'b0, 1'b0, 1'b0, 2'b01, 1, 1);
        addVec(32'h3F800001, 32'h40000000, 8'h80, 24'h400000, 24'h800000, 1'b1, 1'b0, 1'b0, 2'b00, 2, 2);
        addVec(32'h44800000, 32'h3FFFFFFF, 8'h89, 24'h800000, 24'h003FFF, 1'b1, 1'b1, 1'b1, 2'b00, 11, 3);
        addVec(32'h00400000, 32'h3F800000, 8'h7F, 24'h000000, 24'h800000, 1'b0, 1'b0, 1'b0, 2'b01, 1, 1);
        addVec(32'h3F800000, 32'h7FC00001, 8'hFF, 24'h800000, 24'h400001, 1'b0, 1'b0, 1'b0, 2'b10, 1, 1);
        addVec(32'h7F800000, 32'h00000000, 8'hFF, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0, 2'b10, 1, 1);
        addVec(32'h00000000, 32'h00000000, 8'h00, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0, 2'b01, 1, 1);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++)
            checkOutput($sformatf("dut%0d_in_ready_in_reset", g), 32'(inReady[g]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("dut%0d_rst_out_valid", g), 32'(outValid[g]), 32'd0);
            checkOutput($sformatf("dut%0d_rst_in_ready", g), 32'(inReady[g]), 32'd1);
            checkOutput($sformatf("dut%0d_rst_exp_out", g), 32'(expOut[g]), 32'd0);
            checkOutput($sformatf("dut%0d_rst_aligned", g), 32'({alignedA[g], alignedB[g]}), 32'd0);
            checkOutput($sformatf("dut%0d_rst_grs_spc", g),
                        32'({guardO[g], roundO[g], stickyO[g], specialO[g]}), 32'd0);
        end

        // Directed vectors, free-flowing output
        foreach (vecTab[i]) applyStimulus(vecTab[i]);

        // in_valid pulsed while both instances are shifting must not capture
        applyStimulus(vecTab[2]);
        a = 32'h3F800000;
        b = 32'h3F800000;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;

        // Back-pressure in DONE, then consume with a simultaneous in_valid
        waitIdle();
        outReady = 1'b0;
        applyStimulus(vecTab[1]);
        n = 0;
        while (!(outValid[0] && outValid[1]) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("bp_reach_done", 32'(outValid[0] && outValid[1]), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        a = 32'h40400000;
        b = 32'h3F800000;
        outReady = 1'b1;
        inValid  = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;

        // Reset in the middle of a long shift abandons the operation
        applyStimulus(vecTab[3]);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++)
            checkOutput($sformatf("dut%0d_in_ready_mid_reset", g), 32'(inReady[g]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rdIdx[0] = expQ.size();
        rdIdx[1] = expQ.size();
        inDone[0] = 1'b0;
        inDone[1] = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("dut%0d_abort_out_valid", g), 32'(outValid[g]), 32'd0);
            checkOutput($sformatf("dut%0d_abort_in_ready", g), 32'(inReady[g]), 32'd1);
            checkOutput($sformatf("dut%0d_abort_exp_out", g), 32'(expOut[g]), 32'd0);
        end

        // Recovery after the abort
        applyStimulus(vecTab[7]);
        applyStimulus(vecTab[0]);
        waitIdle();
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++)
            checkOutput($sformatf("dut%0d_results_seen", g), 32'(rdIdx[g]), 32'(expQ.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
